// File: rtl/fetch_buffer_if.sv
// Instruction-fetch entry stream: one PC pair plus instruction word per transfer.
// Handshake: master holds valid and payload steady until ready is seen; a transfer happens on every rising edge where valid & ready are both 1.
interface fetch_buffer_if #(
  parameter int PC_W = 64
);
  logic            valid;
  logic            ready;
  logic [PC_W-1:0] now_pc;
  logic [PC_W-1:0] pc_plus_4;
  logic [31:0]     instruction;

  modport master (
    output valid,
    output now_pc,
    output pc_plus_4,
    output instruction,
    input  ready
  );

  modport slave (
    input  valid,
    input  now_pc,
    input  pc_plus_4,
    input  instruction,
    output ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Circular FIFO between the fetch unit and the IF/ID register, with flush and async reset.
// Optional macro FETCH_BUF_BYPASS_EN: zero-latency pass-through of the input when the buffer is empty.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     flush,
  fetch_buffer_if.slave            in_if,
  fetch_buffer_if.master           out_if,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] pc_mem  [DEPTH];
  logic [PC_W-1:0] pc4_mem [DEPTH];
  logic [31:0]     ins_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic not_full;
  logic not_empty;
  logic bypass;
  logic out_valid;
  logic push;
  logic pop;
  logic store;
  logic deq;

  assign not_full  = (count_q < CW'(DEPTH));
  assign not_empty = (count_q != '0);

`ifdef FETCH_BUF_BYPASS_EN
  // Empty buffer and a consumer ready: hand the input straight through without storing it.
  assign bypass = ~not_empty & in_if.valid & out_if.ready & ~flush & sys_rst;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = (not_empty & ~flush) | bypass;
  assign push      = in_if.valid & not_full & ~flush;
  assign pop       = out_valid & out_if.ready & ~flush;
  assign store     = push & ~bypass;
  assign deq       = pop & ~bypass;

  assign in_if.ready  = not_full;
  assign out_if.valid = out_valid;
  assign count        = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({store, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge sys_clk) begin
    if (store) begin
      pc_mem[wr_ptr_q]  <= in_if.now_pc;
      pc4_mem[wr_ptr_q] <= in_if.pc_plus_4;
      ins_mem[wr_ptr_q] <= in_if.instruction;
    end
  end

  always_comb begin
    out_if.now_pc      = '0;
    out_if.pc_plus_4   = '0;
    out_if.instruction = '0;
    if (bypass) begin
      out_if.now_pc      = in_if.now_pc;
      out_if.pc_plus_4   = in_if.pc_plus_4;
      out_if.instruction = in_if.instruction;
    end else if (out_valid) begin
      out_if.now_pc      = pc_mem[rd_ptr_q];
      out_if.pc_plus_4   = pc4_mem[rd_ptr_q];
      out_if.instruction = ins_mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus random traffic against a queue model.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int PC_W  = 64;
  localparam int W     = 2 * PC_W + 32;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic flush   = 1'b0;
  logic [$clog2(DEPTH):0] count;

  fetch_buffer_if #(.PC_W(PC_W)) in_if ();
  fetch_buffer_if #(.PC_W(PC_W)) out_if ();

  fetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .flush   (flush),
    .in_if   (in_if),
    .out_if  (out_if),
    .count   (count)
  );

  always #5 sys_clk = ~sys_clk;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Driver
  task automatic drive(input bit v, input logic [PC_W-1:0] pc, input logic [31:0] ins,
                       input bit rdy, input bit fl);
    in_if.valid       = v;
    in_if.now_pc      = pc;
    in_if.pc_plus_4   = pc + 64'd4;
    in_if.instruction = ins;
    out_if.ready      = rdy;
    flush             = fl;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, '0, '0, rdy, 1'b0);
  endtask

  // Monitor: compares DUT outputs with the model, then applies this cycle's transfers to the model.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      int sz;
      bit byp;
      logic [W-1:0] head;
      sz  = exp_q.size();
      byp = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
      byp = (sz == 0) && in_if.valid && out_if.ready && !flush;
`endif
      chk("count", 64'(count), 64'(sz));
      chk("in_ready", 64'(in_if.ready), 64'(sz < DEPTH));
      chk("out_valid", 64'(out_if.valid), 64'(!flush && (sz > 0 || byp)));
      if (byp) begin
        chk("bypass_pc", out_if.now_pc, in_if.now_pc);
        chk("bypass_instr", 64'(out_if.instruction), 64'(in_if.instruction));
      end else if (!flush && sz > 0) begin
        head = exp_q[0];
        chk("out_pc", out_if.now_pc, head[W-1 -: PC_W]);
        chk("out_pc4", out_if.pc_plus_4, head[PC_W+31 -: PC_W]);
        chk("out_instr", 64'(out_if.instruction), 64'(head[31:0]));
        if (out_if.ready) void'(exp_q.pop_front());
      end else begin
        chk("idle_data", out_if.now_pc | out_if.pc_plus_4 | 64'(out_if.instruction), 64'd0);
      end
      if (flush) exp_q.delete();
      else if (in_if.valid && sz < DEPTH && !byp)
        exp_q.push_back({in_if.now_pc, in_if.pc_plus_4, in_if.instruction});
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_if.valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_if.ready), 64'd1);
    chk({tag, "_data"}, out_if.now_pc | out_if.pc_plus_4 | 64'(out_if.instruction), 64'd0);
  endtask

  initial begin
    logic [PC_W-1:0] pc;
    in_if.valid = 1'b0; in_if.now_pc = '0; in_if.pc_plus_4 = '0; in_if.instruction = '0;
    out_if.ready = 1'b0;
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk_reset_state("reset");
    sys_rst = 1'b1;

    // Fill to full with the consumer stalled; the fifth entry must be refused.
    for (int i = 0; i < 4; i++) drive(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h13 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 64'h8000_0010, 32'hdead, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_if.ready), 64'd0);
    // Drain in order.
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b1);
    chk("drained_count", 64'(count), 64'd0);

    // Occupancy 2 with push and pop every cycle across pointer wrap.
    pc = 64'h1000;
    for (int i = 0; i < 2; i++) begin drive(1'b1, pc, $urandom, 1'b0, 1'b0); pc += 4; end
    for (int i = 0; i < 2 * DEPTH; i++) begin drive(1'b1, pc, $urandom, 1'b1, 1'b0); pc += 4; end
    chk("steady_count", 64'(count), 64'd2);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Flush with a competing input.
    for (int i = 0; i < 3; i++) drive(1'b1, 64'h2000 + 64'(4 * i), $urandom, 1'b0, 1'b0);
    drive(1'b1, 64'h2bad, 32'hbad, 1'b1, 1'b1);
    chk("post_flush_count", 64'(count), 64'd0);
    idle(1'b1);

    // Single entry into an empty buffer with the consumer ready.
    drive(1'b1, 64'h3000, 32'h0010_0073, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset in the middle of a cycle with three entries queued.
    for (int i = 0; i < 3; i++) drive(1'b1, 64'h4000 + 64'(4 * i), $urandom, 1'b0, 1'b0);
    in_if.valid = 1'b1; in_if.now_pc = 64'h4bad; out_if.ready = 1'b1;
    #1 sys_rst = 1'b0;
    #1 chk_reset_state("async_reset");
    exp_q.delete();
    @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    drive(1'b1, 64'h5000, 32'h5000, 1'b0, 1'b0);
    drive(1'b1, 64'h5004, 32'h5004, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Random traffic.
    pc = 64'h9000_0000;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), pc, $urandom, 1'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 19) == 0));
      pc += 4;
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    chk("final_count", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter PC_W, default 64, PC width (matches the `width` macro).
REQ-003 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  redirect/branch-taken; discard all queued entries.
REQ-006 in_valid  input  1  fetch unit presents an entry.
REQ-007 in_ready  output  1  buffer accepts an entry this cycle.
REQ-008 in_now_pc  input  PC_W  PC of the fetched instruction.
REQ-009 in_pc_plus_4  input  PC_W  PC+4 of the fetched instruction.
REQ-010 in_instruction  input  32  fetched instruction word.
REQ-011 out_valid  output  1  head entry available to the IF/ID register.
REQ-012 out_ready  input  1  IF/ID register consumes the head entry (stall when 0).
REQ-013 out_now_pc, out_pc_plus_4  output  PC_W  head entry PCs.
REQ-014 out_instruction  output  32  head entry instruction.
REQ-015 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-016 Push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
REQ-017 in_ready SHALL be 1 iff count < DEPTH; it does not depend on out_ready (no pass-through on full).
REQ-018 out_valid SHALL be 1 iff count > 0, except as given in REQ-028.
REQ-019 out_* data SHALL reflect the head entry when out_valid=1, and all-zero when out_valid=0.
REQ-020 Entries SHALL leave in strict FIFO order; each accepted entry is emitted exactly once unless flushed.
REQ-021 Read and write pointers SHALL wrap from DEPTH-1 to 0; full versus empty is distinguished by count.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; this is legal at any non-full, non-empty occupancy, and at empty only when REQ-028 applies.
REQ-023 Latency (macro off): an entry pushed in cycle N is visible at out_* in cycle N+1 at the earliest.
REQ-024 flush=1 SHALL zero the pointers and count at the next edge; push and pop in that cycle are suppressed; out_valid SHALL be 0 in the flush cycle.
REQ-025 flush has priority over push, pop and bypass.
REQ-026 While out_ready=0 the head entry and out_* SHALL stay stable.

Reset
REQ-027 sys_rst=0 SHALL immediately clear the pointers and count to 0, drive out_valid=0, in_ready=1 and out_* data=0, independent of sys_clk; this applies mid-transfer, and no partial entry survives. Entry storage contents need not be cleared.

Configuration
REQ-028 Macro FETCH_BUF_BYPASS_EN. When defined: with count=0, in_valid=1, out_ready=1 and flush=0, the input entry SHALL appear combinationally on out_* with out_valid=1 and be consumed without being stored (zero latency, count stays 0). When undefined: no combinational path from in_* to out_*, and REQ-023 applies.

Verification
REQ-029 Reset then 4 pushes (PC 0x80000000, +4, +8, +C) with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is not accepted.
REQ-030 Full buffer, then out_ready=1 for 4 cycles -> out_now_pc 0x80000000..0x8000000C in order, count reaches 0, out_valid=0.
REQ-031 count=2 with simultaneous push/pop each cycle for 2*DEPTH cycles -> count stays 2, order is preserved across pointer wrap.
REQ-032 count=3, flush=1 together with in_valid=1 -> out_valid=0 in that cycle; next cycle count=0 and the flush-cycle entry is absent.
REQ-033 Macro defined: empty buffer, in_valid=1, out_ready=1, in_instruction=0x00100073 -> out_instruction=0x00100073 in the same cycle, count stays 0. Macro undefined: it appears one cycle later.
REQ-034 sys_rst asserted low mid-cycle with count=3 -> out_valid=0, count=0 before the next clock edge; after release, the first push is emitted first.
